// File: rtl/mem_fifo_ctrl_pkg.sv
// Shared parameters, types and pointer helper for the memory-backed FIFO controller.
package mem_fifo_ctrl_pkg;

  localparam int WIDTH     = 64;
  localparam int DEPTH     = 32;
  localparam int ADDR_W    = 5;
  localparam int MEM_CAP   = 31;
  localparam int BUF_DEPTH = 2;
  localparam int CNT_W     = 6;
  localparam int BUF_CNT_W = 2;

  typedef logic [WIDTH-1:0]     word_t;
  typedef logic [ADDR_W-1:0]    addr_t;
  typedef logic [BUF_CNT_W-1:0] buf_cnt_t;

  // Advance a memory pointer by one slot, wrapping at the top of the memory.
  function automatic addr_t ptr_inc(input addr_t p);
    return (p == addr_t'(DEPTH - 1)) ? '0 : p + addr_t'(1);
  endfunction

endpackage

// File: rtl/mem_fifo_ctrl_out_buf.sv
// Two-entry in-order output buffer that absorbs registered memory read data.
module fifo_out_buf
  import mem_fifo_ctrl_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     push,
  input  logic     pop,
  input  word_t    push_data,
  output word_t    head_data,
  output buf_cnt_t count
);

  buf_cnt_t count_q, count_d;
  buf_cnt_t kept;
  word_t    slot0_q, slot0_d;
  word_t    slot1_q, slot1_d;

  // Shift out the head on pop, then place a new word behind whatever remains.
  always_comb begin
    count_d = count_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    kept    = count_q - buf_cnt_t'(pop);
    if (pop) begin
      slot0_d = slot1_q;
    end
    if (push) begin
      if (kept == '0) begin
        slot0_d = push_data;
      end else begin
        slot1_d = push_data;
      end
    end
    count_d = kept + buf_cnt_t'(push);
  end

  // Occupancy is control state and is cleared by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Data slots carry no meaning while empty, so they are not reset.
  always_ff @(posedge clock) begin
    slot0_q <= slot0_d;
    slot1_q <= slot1_d;
  end

  assign head_data = slot0_q;
  assign count     = count_q;

endmodule

// File: rtl/mem_fifo_ctrl.sv
// FIFO controller around an external 32x64 read-first memory with a registered
// read port; a 2-entry output buffer hides the read latency for full throughput.
module mem_fifo_ctrl
  import mem_fifo_ctrl_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [WIDTH-1:0] mem_rdata
);

  addr_t    wr_ptr_q, wr_ptr_d;
  addr_t    rd_ptr_q, rd_ptr_d;
  logic     rvalid_q, rvalid_d;
  addr_t    mem_count;
  buf_cnt_t buf_count;
  logic     push, pop, issue;
  logic [2:0] pending;

  // The slot at wr_ptr is always free, so the memory can write every cycle.
  assign mem_count = wr_ptr_q - rd_ptr_q;
  assign in_ready  = (mem_count != addr_t'(MEM_CAP));
  assign out_valid = (buf_count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Words already owed to the buffer after this cycle's pop; only issue if one more fits.
  assign pending = 3'(buf_count) + 3'(rvalid_q) - 3'(pop);
  assign issue   = (mem_count != '0) && (pending < 3'(BUF_DEPTH));

  // Next-state for the pointers and the one-cycle read-valid flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rvalid_d = issue;
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (issue) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
  end

  // Control state; reset also drops any read that is in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rvalid_q <= rvalid_d;
    end
  end

  fifo_out_buf u_out_buf (
    .clock     (clock),
    .reset     (reset),
    .push      (rvalid_q),
    .pop       (pop),
    .push_data (mem_rdata),
    .head_data (out_data),
    .count     (buf_count)
  );

  assign count     = CNT_W'(mem_count) + CNT_W'(rvalid_q) + CNT_W'(buf_count);
  assign mem_waddr = wr_ptr_q;
  assign mem_wdata = in_data;
  assign mem_raddr = rd_ptr_q;

endmodule
